freq_sweep_sequencer: RTL and testbench

Sweep initiator that drives one single-frequency amplitude/phase measurement unit through a programmed list of frequency points. For each point it presents the frequency and the settle delay, pulses start, and waits for done. It then stores the unit's amp/phase result in an internal result RAM that the host/UART readout path can read back. It sits between the host command decoder and the measurement unit.

---
 rtl/freq_sweep_sequencer.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_freq_sweep_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_sequencer.sv
// freq_sweep_sequencer
// Steps a single-point amplitude/phase measurement unit through a list of
// frequency points. Each completed point's {amp, phase} goes into a result RAM
// that the readout path reads through a registered port.
// Optional build macro: SWEEP_PEAK_TRACK_EN (tracks the largest amplitude seen
// in the sweep and the point index where it occurred).
module freq_sweep_sequencer #(
  parameter int ADDR_W           = 8,
  parameter int RESTART_GAP      = 4,
  parameter int DONE_TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sweep_start,
  input  logic              sweep_abort,
  input  logic [13:0]       f_start,
  input  logic [13:0]       f_step,
  input  logic [ADDR_W:0]   n_points,
  input  logic [15:0]       settle_us,
  output logic              busy,
  output logic              sweep_done,
  output logic              timeout_err,
  output logic [ADDR_W:0]   pts_valid,
  output logic              unit_start,
  output logic [13:0]       unit_freq,
  output logic [15:0]       unit_delay_us,
  input  logic              unit_done,
  input  logic [11:0]       unit_amp,
  input  logic [11:0]       unit_phase,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [23:0]       rd_data,
  output logic [11:0]       peak_amp,
  output logic [ADDR_W-1:0] peak_idx
);

  localparam int MAX_POINTS = 1 << ADDR_W;
  localparam int TCNT_W     = (DONE_TIMEOUT_CYC > 2) ? $clog2(DONE_TIMEOUT_CYC) : 1;
  localparam int GCNT_W     = (RESTART_GAP > 2) ? $clog2(RESTART_GAP) : 1;

  localparam logic [ADDR_W:0] MAX_PTS_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(DONE_TIMEOUT_CYC - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(RESTART_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_STORE,
    ST_GAP,
    ST_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   n_eff_q, n_eff_d;
  logic [13:0]       f_step_q, f_step_d;
  logic [15:0]       settle_q, settle_d;
  logic [14:0]       acc_q, acc_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   pts_q, pts_d;
  logic              tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_q, start_d;
  logic [13:0]       freq_q, freq_d;
  logic [15:0]       delay_q, delay_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [11:0]       amp_q, amp_d;
  logic [11:0]       phase_q, phase_d;
  logic              we;
  logic [23:0]       rd_q;
  logic [23:0]       mem_q [MAX_POINTS];

  // Unit frequency is the accumulator clamped to the 14-bit range
  function automatic logic [13:0] sat_freq(input logic [14:0] a);
    return a[14] ? 14'h3FFF : a[13:0];
  endfunction

  // Accumulator step that sticks at full scale instead of wrapping
  function automatic logic [14:0] acc_add_sat(input logic [14:0] a, input logic [13:0] s);
    logic [15:0] sum;
    sum = {1'b0, a} + {2'b00, s};
    return sum[15] ? 15'h7FFF : sum[14:0];
  endfunction

  // Next-state logic: sequencing, point bookkeeping and registered output values
  always_comb begin
    state_d  = state_q;
    n_eff_d  = n_eff_q;
    f_step_d = f_step_q;
    settle_d = settle_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    pts_d    = pts_q;
    tmo_d    = tmo_q;
    freq_d   = freq_q;
    delay_d  = delay_q;
    tcnt_d   = tcnt_q;
    gcnt_d   = gcnt_q;
    amp_d    = amp_q;
    phase_d  = phase_q;
    we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sweep_start) begin
          n_eff_d  = (n_points > MAX_PTS_V) ? MAX_PTS_V : n_points;
          f_step_d = f_step;
          settle_d = settle_us;
          pts_d    = '0;
          tmo_d    = 1'b0;
          idx_d    = '0;
          acc_d    = {1'b0, f_start};
          state_d  = (n_eff_d == '0) ? ST_FINISH : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tcnt_d  = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (unit_done) begin
          amp_d   = unit_amp;
          phase_d = unit_phase;
          state_d = ST_STORE;
        end else if (tcnt_q == TCNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_FINISH;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_STORE: begin
        we      = 1'b1;
        pts_d   = idx_q + 1'b1;
        idx_d   = idx_q + 1'b1;
        acc_d   = acc_add_sat(acc_q, f_step_q);
        gcnt_d  = '0;
        state_d = ((idx_q + 1'b1) == n_eff_q) ? ST_FINISH : ST_GAP;
      end
      ST_GAP: begin
        if (gcnt_q == GCNT_LAST) begin
          state_d = ST_SETUP;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a coincident unit_done; nothing
    // from the in-flight point is committed.
    if (sweep_abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
      state_d = ST_FINISH;
      we      = 1'b0;
      pts_d   = pts_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      tmo_d   = tmo_q;
    end

    busy_d  = (state_d != ST_IDLE) && (state_d != ST_FINISH);
    done_d  = (state_d == ST_FINISH);
    start_d = (state_d == ST_ISSUE);

    // Frequency and delay change only on entry to SETUP, so they lead the start pulse
    if (state_d == ST_SETUP) begin
      freq_d  = sat_freq(acc_d);
      delay_d = settle_d;
    end
  end

  // State and control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      n_eff_q  <= '0;
      f_step_q <= '0;
      settle_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      pts_q    <= '0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      freq_q   <= '0;
      delay_q  <= '0;
      tcnt_q   <= '0;
      gcnt_q   <= '0;
      amp_q    <= '0;
      phase_q  <= '0;
    end else begin
      state_q  <= state_d;
      n_eff_q  <= n_eff_d;
      f_step_q <= f_step_d;
      settle_q <= settle_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      pts_q    <= pts_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      start_q  <= start_d;
      freq_q   <= freq_d;
      delay_q  <= delay_d;
      tcnt_q   <= tcnt_d;
      gcnt_q   <= gcnt_d;
      amp_q    <= amp_d;
      phase_q  <= phase_d;
    end
  end

  // Result RAM write port; contents are not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[idx_q[ADDR_W-1:0]] <= {amp_q, phase_q};
    end
  end

  // Registered read port; a same-cycle write to rd_addr returns the old word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[rd_addr];
    end
  end

`ifdef SWEEP_PEAK_TRACK_EN
  logic [11:0]       peak_amp_q, peak_amp_d;
  logic [ADDR_W-1:0] peak_idx_q, peak_idx_d;

  // Running maximum of stored amplitudes; strict compare keeps the earliest index on ties
  always_comb begin
    peak_amp_d = peak_amp_q;
    peak_idx_d = peak_idx_q;
    if ((state_q == ST_IDLE) && sweep_start) begin
      peak_amp_d = '0;
      peak_idx_d = '0;
    end else if (we && (amp_q > peak_amp_q)) begin
      peak_amp_d = amp_q;
      peak_idx_d = idx_q[ADDR_W-1:0];
    end
  end

  // Peak tracker registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_amp_q <= '0;
      peak_idx_q <= '0;
    end else begin
      peak_amp_q <= peak_amp_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  assign peak_amp = peak_amp_q;
  assign peak_idx = peak_idx_q;
`else
  assign peak_amp = '0;
  assign peak_idx = '0;
`endif

  assign busy          = busy_q;
  assign sweep_done    = done_q;
  assign timeout_err   = tmo_q;
  assign pts_valid     = pts_q;
  assign unit_start    = start_q;
  assign unit_freq     = freq_q;
  assign unit_delay_us = delay_q;
  assign rd_data       = rd_q;

endmodule

// File: tb/tb_freq_sweep_sequencer.sv
// Scoreboard bench for freq_sweep_sequencer: a behavioural measurement-unit
// model answers each start; expected start/end/readback records are queued at
// stimulus time and popped by independent monitors.
module tb_freq_sweep_sequencer;
  localparam int AW   = 4;
  localparam int MAXP = 16;
  localparam int GAP  = 4;
  localparam int TO   = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sweep_start = 1'b0;
  logic          sweep_abort;
  logic [13:0]   f_start = '0, f_step = '0;
  logic [AW:0]   n_points = '0;
  logic [15:0]   settle_us = '0;
  logic          busy, sweep_done, timeout_err, unit_start;
  logic [AW:0]   pts_valid;
  logic [13:0]   unit_freq;
  logic [15:0]   unit_delay_us;
  logic          unit_done;
  logic [11:0]   unit_amp, unit_phase, peak_amp;
  logic [AW-1:0] rd_addr, peak_idx;
  logic [23:0]   rd_data;

  freq_sweep_sequencer #(.ADDR_W(AW), .RESTART_GAP(GAP), .DONE_TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .f_start(f_start), .f_step(f_step), .n_points(n_points), .settle_us(settle_us),
    .busy(busy), .sweep_done(sweep_done), .timeout_err(timeout_err), .pts_valid(pts_valid),
    .unit_start(unit_start), .unit_freq(unit_freq), .unit_delay_us(unit_delay_us),
    .unit_done(unit_done), .unit_amp(unit_amp), .unit_phase(unit_phase),
    .rd_addr(rd_addr), .rd_data(rd_data), .peak_amp(peak_amp), .peak_idx(peak_idx));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;

  typedef struct { logic [13:0] f; logic [15:0] d; } start_t;
  typedef struct { int pts; int tmo; int pa; int pi; int chk_to; } end_t;
  start_t      sq[$];
  end_t        eq[$];
  logic [23:0] rdq[$];

  // Per-sweep plan (stimulus-owned)
  int          lat[MAXP];
  logic [11:0] pamp[MAXP], pph[MAXP];
  int          hang_at = -1, abort_at = -1, plan_stored = 0, sweep_id = 0;
  bit          model_kill = 1'b0, rbw_en = 1'b1;
  // Reference RAM image (model-owned)
  logic [23:0] exp_mem[MAXP];
  bit          exp_ok[MAXP];
  int          model_pt = 0;
  // Monitor-owned
  int          ndone = 0, done_cyc = 0, last_start = 0, last_done = 0, nstart = 0;

  bit          rd_req_rb = 1'b0, rd_req_rbw = 1'b0;
  logic [AW-1:0] rb_addr = '0, rbw_addr = '0;
  assign rd_addr = rd_req_rbw ? rbw_addr : rb_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Measurement-unit model: answers each start after lat[] cycles unless told to hang
  initial begin : unit_model
    int p, my_id;
    unit_done = 1'b0; sweep_abort = 1'b0; unit_amp = '0; unit_phase = '0;
    my_id = -1;
    forever begin
      @(negedge clk);
      if (rst && unit_start) begin
        if (my_id != sweep_id) begin my_id = sweep_id; model_pt = 0; end
        p = model_pt;
        model_pt++;
        if (p != hang_at) begin
          repeat (lat[p]) @(posedge clk);
          #1;
          if (!model_kill) begin
            unit_amp = pamp[p]; unit_phase = pph[p]; unit_done = 1'b1;
            sweep_abort = (p == abort_at);
            @(posedge clk); #1;
            unit_done = 1'b0; sweep_abort = 1'b0;
            if (p < plan_stored) begin
              if (rbw_en && exp_ok[p]) begin
                rbw_addr = AW'(p); rd_req_rbw = 1'b1; rdq.push_back(exp_mem[p]);
              end
              exp_mem[p] = {pamp[p], pph[p]};
              exp_ok[p]  = 1'b1;
              @(posedge clk); #1;
              rd_req_rbw = 1'b0;
            end
          end
        end
      end
    end
  end

  // Read monitor: a read requested before an edge is compared after it
  initial begin : read_monitor
    bit rpend;
    forever begin
      @(posedge clk);
      rpend = rd_req_rb | rd_req_rbw;
      @(negedge clk);
      if (rpend) begin
        if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_data", rd_data, rdq.pop_front());
      end
    end
  end

  // Event monitor: unit_start, unit_done and sweep_done against queued expectations
  initial begin : event_monitor
    start_t s; end_t e;
    logic [13:0] prev_f, cur_f;
    int my_id;
    prev_f = '0; cur_f = '0; my_id = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (my_id != sweep_id) begin my_id = sweep_id; nstart = 0; end
        if (unit_start) begin
          if (sq.size() == 0) chk("unexpected_unit_start", 1, 0);
          else begin
            s = sq.pop_front();
            chk("unit_freq", unit_freq, s.f);
            chk("unit_delay_us", unit_delay_us, s.d);
          end
          chk("freq_before_start", prev_f, unit_freq);
          if (nstart > 0) chk("restart_gap", (cyc - last_done) >= GAP + 3, 1);
          nstart++; last_start = cyc; cur_f = unit_freq;
        end
        if (unit_done) begin
          chk("freq_held_in_wait", unit_freq, cur_f);
          last_done = cyc;
        end
        if (sweep_done) begin
          if (eq.size() == 0) chk("unexpected_sweep_done", 1, 0);
          else begin
            e = eq.pop_front();
            chk("pts_valid", pts_valid, e.pts);
            chk("timeout_err", timeout_err, e.tmo);
            chk("busy_at_done", busy, 0);
            chk("peak_amp", peak_amp, e.pa);
            chk("peak_idx", peak_idx, e.pi);
            if (e.chk_to != 0)
              chk("timeout_latency", ((cyc - last_start) >= TO) && ((cyc - last_start) <= TO + 3), 1);
          end
          ndone++; done_cyc = cyc;
        end
        prev_f = unit_freq;
      end
    end
  end

  task automatic plan_random(input int n);
    for (int k = 0; k < MAXP; k++) begin
      lat[k]  = $urandom_range(3, 25);
      pamp[k] = 12'($urandom_range(0, 4095));
      pph[k]  = 12'($urandom_range(0, 4095));
    end
    hang_at = -1; abort_at = -1;
    if (n > 0 && $urandom_range(0, 4) == 0) hang_at = $urandom_range(0, n - 1);
    else if (n > 0 && $urandom_range(0, 4) == 0) abort_at = $urandom_range(0, n - 1);
  endtask

  // Issue one sweep: queue reference expectations, drive, wait, read back results
  task automatic run_sweep(input int fs, input int fst, input int n, input int settle);
    int n_eff, nissued, f, pa, pi, d0, t, sc;
    start_t s; end_t e;
    n_eff = (n > MAXP) ? MAXP : n;
    nissued = n_eff; plan_stored = n_eff;
    if (hang_at >= 0 && hang_at < n_eff) begin nissued = hang_at + 1; plan_stored = hang_at; end
    else if (abort_at >= 0 && abort_at < n_eff) begin nissued = abort_at + 1; plan_stored = abort_at; end
    for (int k = 0; k < nissued; k++) begin
      f = fs + k * fst;
      s.f = 14'((f > 16383) ? 16383 : f);
      s.d = 16'(settle);
      sq.push_back(s);
    end
    pa = 0; pi = 0;
`ifdef SWEEP_PEAK_TRACK_EN
    for (int k = 0; k < plan_stored; k++) if (int'(pamp[k]) > pa) begin pa = pamp[k]; pi = k; end
`endif
    e.pts = plan_stored; e.tmo = (nissued > plan_stored && hang_at >= 0) ? 1 : 0;
    e.pa = pa; e.pi = pi; e.chk_to = e.tmo;
    eq.push_back(e);

    d0 = ndone;
    @(negedge clk);
    sweep_id++;
    f_start = 14'(fs); f_step = 14'(fst); n_points = (AW+1)'(n); settle_us = 16'(settle);
    sweep_start = 1'b1; sc = cyc;
    @(negedge clk);
    sweep_start = 1'b0;
    chk("busy_after_start", busy, (n_eff != 0) ? 1 : 0);
    if (n_eff != 0) begin
      // A second start while busy, with different operands, must be ignored
      repeat (2) @(negedge clk);
      f_start = 14'($urandom_range(0, 16383)); f_step = 14'($urandom_range(0, 16383));
      n_points = (AW+1)'($urandom_range(0, 31)); settle_us = 16'($urandom);
      sweep_start = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
    end
    t = 0;
    while (ndone == d0 && t < 4000) begin @(negedge clk); t++; end
    chk("sweep_done_seen", (ndone != d0) ? 1 : 0, 1);
    if (n_eff == 0) chk("empty_sweep_latency", ((done_cyc - sc) >= 1) && ((done_cyc - sc) <= 2), 1);
    repeat (3) @(negedge clk);
    chk("starts_consumed", sq.size(), 0);
    chk("timeout_err_sticky", timeout_err, e.tmo);
    for (int k = 0; k < plan_stored; k++) begin
      rb_addr = AW'(k); rd_req_rb = 1'b1; rdq.push_back(exp_mem[k]);
      @(negedge clk);
    end
    rd_req_rb = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sweep_done"}, sweep_done, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_pts_valid"}, pts_valid, 0);
    chk({tag, "_unit_start"}, unit_start, 0);
    chk({tag, "_unit_freq"}, unit_freq, 0);
    chk({tag, "_unit_delay"}, unit_delay_us, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_peak_amp"}, peak_amp, 0);
    chk({tag, "_peak_idx"}, peak_idx, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1);
  end

  initial begin : stimulus
    int t;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Four points, fixed latency, amp = idx*10
    plan_random(4);
    hang_at = -1; abort_at = -1;
    for (int k = 0; k < 4; k++) begin lat[k] = 20; pamp[k] = 12'(k * 10); end
    run_sweep(100, 50, 4, 250);

    // Frequency saturation at the top of the code range
    plan_random(3); hang_at = -1; abort_at = -1;
    run_sweep(16300, 50, 3, 7);

    // Empty sweep
    plan_random(0);
    run_sweep(500, 10, 0, 9);

    // Unit hangs on the third point
    plan_random(5); hang_at = 2; abort_at = -1;
    run_sweep(1000, 3, 5, 33);

    // Abort coincident with the second done
    plan_random(4); hang_at = -1; abort_at = 1;
    run_sweep(2000, 100, 4, 44);

    // Peak tie keeps the earlier index
    plan_random(4); hang_at = -1; abort_at = -1;
    pamp[0] = 12'd5; pamp[1] = 12'd30; pamp[2] = 12'd30; pamp[3] = 12'd12;
    run_sweep(300, 1, 4, 1);

    // Point count beyond the RAM depth is clamped
    plan_random(16); hang_at = -1; abort_at = -1;
    run_sweep(50, 700, 20, 12);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(0, 20);
      plan_random((n > MAXP) ? MAXP : n);
      run_sweep(($urandom_range(0, 3) == 0) ? $urandom_range(15000, 16383) : $urandom_range(0, 16383),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 600),
                n, $urandom_range(0, 65535));
    end

    // Reset in the middle of a sweep
    plan_random(6); hang_at = -1; abort_at = -1;
    for (int k = 0; k < 6; k++) lat[k] = 10;
    sq.push_back('{f: 14'd0, d: 16'd0});
    sq.delete();
    plan_stored = 6;
    for (int k = 0; k < 6; k++) sq.push_back('{f: 14'(4000 + k * 20), d: 16'd77});
    @(negedge clk);
    sweep_id++;
    f_start = 14'd4000; f_step = 14'd20; n_points = (AW+1)'(6); settle_us = 16'd77;
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    t = 0;
    while (model_pt < 3 && t < 2000) begin @(negedge clk); t++; end
    chk("mid_sweep_reached", (model_pt >= 3) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    model_kill = 1'b1;
    rst = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (40) @(negedge clk);
    sq.delete(); eq.delete();
    rbw_en = 1'b0;
    rst = 1'b1;
    model_kill = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", busy, 0);

    // Recovery sweep after reset
    plan_random(5); hang_at = -1; abort_at = -1;
    run_sweep(1234, 321, 5, 999);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
